dds_wave_gen: RTL and testbench

Phase-accumulator waveform generator that produces the signed 8-bit two's-complement sample stream. The downstream DAC offset-binary stage consumes this stream on its `sine` input. Supported waveforms are sawtooth, triangle, square and zero, with programmable frequency, phase offset and power-of-two attenuation. Frequency changes are double-buffered and applied only at a phase wrap, so the output stays glitch-free.

---
 rtl/dds_wave_gen.sv | 135 +++++++++++++
 tb/tb_dds_wave_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// Phase-accumulator waveform generator: saw/triangle/square/zero with wrap-synchronised
// frequency updates, phase offset and power-of-two attenuation, three-stage output pipeline.
module dds_wave_gen #(
  parameter int               ACC_W     = 24,
  parameter logic [ACC_W-1:0] FWORD_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [ACC_W-1:0] fword_in,
  input  logic             fword_load,
  input  logic [1:0]       wave_sel,
  input  logic [2:0]       amp_shift,
  input  logic [7:0]       phase_off,
  output logic [7:0]       sine,
  output logic             sample_valid,
  output logic             wrap
);

  localparam logic [1:0] SEL_SAW    = 2'b00;
  localparam logic [1:0] SEL_TRI    = 2'b01;
  localparam logic [1:0] SEL_SQUARE = 2'b10;

  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] f_act;
  logic [ACC_W-1:0] f_pend;
  logic             pend_flag;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             advance;
  logic             transfer;

  logic             v0;
  logic [7:0]       p8;
  logic [1:0]       sel1;
  logic [2:0]       amp1;
  logic             v1;
  logic [7:0]       w;
  logic [7:0]       tri_raw;
  logic signed [7:0] w_r;
  logic [2:0]       amp2;
  logic             v2;

  assign sum     = {1'b0, phase} + {1'b0, f_act};
  assign carry   = sum[ACC_W];
  assign advance = en & ~sync;

  // A stalled generator (f_act == 0) never wraps, so a pending word is taken immediately.
  assign transfer = pend_flag & ((advance & carry) | (f_act == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else if (sync) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      phase <= sum[ACC_W-1:0];
      wrap  <= carry;
    end else begin
      wrap  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_act     <= FWORD_RST;
      f_pend    <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (transfer) begin
        f_act <= f_pend;
      end
      if (fword_load) begin
        f_pend    <= fword_in;
        pend_flag <= 1'b1;
      end else if (transfer) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // v0 marks that the accumulator was updated on this edge; it travels with the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0   <= 1'b0;
      p8   <= '0;
      sel1 <= '0;
      amp1 <= '0;
      v1   <= 1'b0;
    end else begin
      v0   <= en | sync;
      p8   <= phase[ACC_W-1 -: 8] + phase_off;
      sel1 <= wave_sel;
      amp1 <= amp_shift;
      v1   <= v0;
    end
  end

  always_comb begin
    tri_raw = p8[7] ? ~{p8[6:0], 1'b0} : {p8[6:0], 1'b0};
    w       = 8'h00;
    case (sel1)
      SEL_SAW:    w = p8 ^ 8'h80;
      SEL_TRI:    w = tri_raw ^ 8'h80;
      SEL_SQUARE: w = p8[7] ? 8'h80 : 8'h7F;
      default:    w = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_r  <= '0;
      amp2 <= '0;
      v2   <= 1'b0;
    end else begin
      w_r  <= w;
      amp2 <= amp1;
      v2   <= v1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sine         <= '0;
      sample_valid <= 1'b0;
    end else begin
      sine         <= w_r >>> amp2;
      sample_valid <= v2;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed self-checking bench for dds_wave_gen: waveforms, attenuation, deferred
// frequency loads, sync, enable hold and mid-operation reset.
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sync;
  logic [23:0] fword_in;
  logic        fword_load;
  logic [1:0]  wave_sel;
  logic [2:0]  amp_shift;
  logic [7:0]  phase_off;
  logic [7:0]  sine;
  logic        sample_valid;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  dds_wave_gen #(.ACC_W(24), .FWORD_RST(24'h000000)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .fword_in(fword_in), .fword_load(fword_load),
    .wave_sel(wave_sel), .amp_shift(amp_shift), .phase_off(phase_off),
    .sine(sine), .sample_valid(sample_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrap(input int limit, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (wrap !== 1'b1 && cnt < limit);
    if (wrap !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_wrap: no wrap within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sync = 1'b0; fword_in = '0; fword_load = 1'b0;
    wave_sel = 2'b00; amp_shift = 3'd0; phase_off = 8'h00;
    #2;
    checks++;
    if (sine !== 8'h00 || sample_valid !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sine=%h valid=%b wrap=%b expected 00 0 0", sine, sample_valid, wrap);
    end
    repeat (2) tick();
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_saw_immediate();
    int cnt;
    int ks[5] = '{0, 1, 127, 128, 255};
    logic [7:0] ex[5] = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h7F};
    fword_in = 24'h010000; fword_load = 1'b1;
    tick();
    fword_load = 1'b0;
    wait_wrap(300, cnt);
    checks++;
    if (cnt != 257) begin
      errors++;
      $display("FAIL immediate_load: first wrap after %0d cycles, expected 257", cnt);
    end
    for (int i = 1; i <= 258; i++) begin
      tick();
      for (int j = 0; j < 5; j++) begin
        if (i == ks[j] + 3) begin
          checks++;
          if (sine !== ex[j]) begin
            errors++;
            $display("FAIL saw p8=%0d: sine=%h expected %h", ks[j], sine, ex[j]);
          end
        end
      end
      if (i == 255 || i == 256) begin
        checks++;
        if (wrap !== (i == 256)) begin
          errors++;
          $display("FAIL saw_wrap_spacing i=%0d: wrap=%b expected %b", i, wrap, (i == 256));
        end
      end
    end
  endtask

  task automatic test_triangle();
    int cnt;
    int ks[5] = '{0, 64, 127, 128, 255};
    logic [7:0] ex[5] = '{8'h80, 8'h00, 8'h7E, 8'h7F, 8'h81};
    wave_sel = 2'b01;
    wait_wrap(300, cnt);
    for (int i = 1; i <= 258; i++) begin
      tick();
      for (int j = 0; j < 5; j++) begin
        if (i == ks[j] + 3) begin
          checks++;
          if (sine !== ex[j]) begin
            errors++;
            $display("FAIL triangle p8=%0d: sine=%h expected %h", ks[j], sine, ex[j]);
          end
        end
      end
    end
  endtask

  task automatic test_square_atten();
    int cnt;
    int ks[4] = '{0, 127, 128, 255};
    logic [7:0] ex1[4] = '{8'h3F, 8'h3F, 8'hC0, 8'hC0};
    logic [7:0] ex7[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    wave_sel = 2'b10; amp_shift = 3'd1;
    wait_wrap(300, cnt);
    for (int i = 1; i <= 258; i++) begin
      tick();
      for (int j = 0; j < 4; j++) begin
        if (i == ks[j] + 3) begin
          checks++;
          if (sine !== ex1[j]) begin
            errors++;
            $display("FAIL square_shift1 p8=%0d: sine=%h expected %h", ks[j], sine, ex1[j]);
          end
        end
      end
    end
    amp_shift = 3'd7;
    wait_wrap(300, cnt);
    for (int i = 1; i <= 258; i++) begin
      tick();
      for (int j = 0; j < 4; j++) begin
        if (i == ks[j] + 3) begin
          checks++;
          if (sine !== ex7[j]) begin
            errors++;
            $display("FAIL square_shift7 p8=%0d: sine=%h expected %h", ks[j], sine, ex7[j]);
          end
        end
      end
    end
    wave_sel = 2'b00; amp_shift = 3'd0;
  endtask

  task automatic test_back_to_back_load();
    int cnt;
    logic exp_wrap[10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
    fword_in = 24'h400000; fword_load = 1'b1;
    tick();
    fword_load = 1'b0;
    wait_wrap(300, cnt);
    wait_wrap(10, cnt);
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL deferred_period4: wrap spacing %0d, expected 4", cnt);
    end
    // One cycle after a wrap: load 0x800000, then a second load on the next carry edge.
    fword_in = 24'h800000; fword_load = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      fword_load = 1'b0;
      if (i == 3) begin
        fword_in = 24'h400000; fword_load = 1'b1;
      end
      checks++;
      if (wrap !== exp_wrap[i-1]) begin
        errors++;
        $display("FAIL deferred_wrap n+%0d: wrap=%b expected %b", i, wrap, exp_wrap[i-1]);
      end
    end
  endtask

  task automatic test_hold();
    int cnt;
    wait_wrap(10, cnt);
    tick();
    en = 1'b0;
    repeat (3) tick();
    checks++;
    if (sine !== 8'hC0 || sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_last_valid: sine=%h valid=%b expected c0 1", sine, sample_valid);
    end
    tick();
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_valid_fall: valid=%b expected 0", sample_valid);
    end
    tick();
    checks++;
    if (sine !== 8'hC0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL hold_sine: sine=%h wrap=%b expected c0 0", sine, wrap);
    end
    en = 1'b1;
  endtask

  task automatic test_sync_offset();
    int cnt;
    phase_off = 8'h40;
    wait_wrap(10, cnt);
    repeat (2) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL sync_no_wrap: wrap=%b expected 0", wrap);
    end
    repeat (2) tick();
    checks++;
    if (sine !== 8'hC0 || sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL sync_offset: sine=%h valid=%b expected c0 1", sine, sample_valid);
    end
    tick();
    checks++;
    if (wrap !== 1'b1) begin
      errors++;
      $display("FAIL sync_next_wrap: wrap=%b expected 1", wrap);
    end
  endtask

  task automatic test_reset_midop();
    int wraps;
    fword_in = 24'h123456; fword_load = 1'b1;
    tick();
    fword_load = 1'b0;
    checks++;
    if (sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL midop_pre_valid: valid=%b expected 1", sample_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sine !== 8'h00 || sample_valid !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL midop_async_reset: sine=%h valid=%b wrap=%b expected 00 0 0", sine, sample_valid, wrap);
    end
    tick();
    rst = 1'b0;
    phase_off = 8'h00;
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wrap === 1'b1) wraps++;
    end
    checks++;
    if (wraps != 0 || sine !== 8'h80 || sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL midop_pending_discard: wraps=%0d sine=%h valid=%b expected 0 80 1", wraps, sine, sample_valid);
    end
  endtask

  initial begin
    test_reset();
    test_saw_immediate();
    test_triangle();
    test_square_atten();
    test_back_to_back_load();
    test_hold();
    test_sync_offset();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
